// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   req_valid/req_ready  request handshake (op, rs1, rs2)
//   req_op               [2]=0 mul/mulh/mulhsu/mulhu, [2]=1 div/divu/rem/remu
//   req_a/req_b          rs1 / rs2 operands, XLEN bits
//   resp_valid/ready     response handshake, result held until taken
//   resp_data            XLEN-bit result
//   resp_div0/resp_ovf   divide-by-zero / signed-overflow flags
interface muldiv_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_div0;
    logic            resp_ovf;

    // Requester side (execute stage)
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_div0, resp_ovf
    );

    // Unit side
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_div0, resp_ovf
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
// Works on operand magnitudes, one result bit per cycle, with a sign fix-up
// cycle at the end. Divide-by-zero and MIN/-1 overflow resolve at accept.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   flush  abort any in-flight op, no response produced
//   bus    muldiv_iter_if.slave request/response bundle
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave the
// iteration loop once the remaining multiplier bits are all zero.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    muldiv_iter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    // Registered state and outputs
    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg_q;      // product / quotient needs negation
    logic            r_neg_r;      // remainder needs negation
    logic [PW-1:0]   r_acc;        // mul: product; div: {remainder, quotient}
    logic [PW-1:0]   r_mcand;      // mul: shifting multiplicand; div: divisor in low half
    logic [XLEN-1:0] r_mplier;     // mul: remaining multiplier bits
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_div0;
    logic            r_resp_ovf;

    // Next-state values
    state_t          w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]      w_op_nxt;
    logic            w_neg_q_nxt;
    logic            w_neg_r_nxt;
    logic [PW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_mcand_nxt;
    logic [XLEN-1:0] w_mplier_nxt;
    logic            w_req_ready_nxt;
    logic            w_resp_valid_nxt;
    logic [XLEN-1:0] w_resp_data_nxt;
    logic            w_resp_div0_nxt;
    logic            w_resp_ovf_nxt;

    // Accept-time operand decode
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_b_zero;
    logic            w_ovf_case;

    assign w_accept   = bus.req_valid & ~flush;
    assign w_a_signed = bus.req_op[2] ? ~bus.req_op[0] : (bus.req_op[1:0] != 2'b11);
    assign w_b_signed = bus.req_op[2] ? ~bus.req_op[0] : ~bus.req_op[1];
    assign w_sa       = w_a_signed & bus.req_a[XLEN-1];
    assign w_sb       = w_b_signed & bus.req_b[XLEN-1];
    assign w_mag_a    = w_sa ? (~bus.req_a + XLEN'(1)) : bus.req_a;
    assign w_mag_b    = w_sb ? (~bus.req_b + XLEN'(1)) : bus.req_b;
    assign w_b_zero   = (bus.req_b == '0);
    // Signed MIN / -1 only applies to div and rem (op[0]==0)
    assign w_ovf_case = bus.req_op[2] & ~bus.req_op[0] & (&bus.req_b)
                      & (bus.req_a == {1'b1, {(XLEN-1){1'b0}}});

    // One shift-add multiply step
    logic [PW-1:0] w_mul_acc;
    assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

    // One restoring divide step: shift next dividend bit into the remainder
    logic [XLEN:0]   w_rem_sh;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_diff;
    assign w_rem_sh   = r_acc[PW-1:XLEN-1];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_mcand[XLEN-1:0]});
    assign w_div_diff = w_rem_sh[XLEN-1:0] - r_mcand[XLEN-1:0];

    // Sign fix-up and result select
    logic [PW-1:0]   w_prod_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_result;
    assign w_prod_fix = r_neg_q ? (~r_acc + PW'(1)) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? (~r_acc[PW-1:XLEN] + XLEN'(1)) : r_acc[PW-1:XLEN];
    assign w_result   = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                                : ((r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                                        : w_prod_fix[PW-1:XLEN]);

    // Next-state and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_op_nxt         = r_op;
        w_neg_q_nxt      = r_neg_q;
        w_neg_r_nxt      = r_neg_r;
        w_acc_nxt        = r_acc;
        w_mcand_nxt      = r_mcand;
        w_mplier_nxt     = r_mplier;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_data_nxt  = r_resp_data;
        w_resp_div0_nxt  = r_resp_div0;
        w_resp_ovf_nxt   = r_resp_ovf;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt        = bus.req_op;
                    w_cnt_nxt       = '0;
                    w_neg_q_nxt     = w_sa ^ w_sb;
                    w_neg_r_nxt     = w_sa;
                    w_resp_div0_nxt = 1'b0;
                    w_resp_ovf_nxt  = 1'b0;
                    if (bus.req_op[2] && w_b_zero) begin
                        w_resp_data_nxt  = bus.req_op[1] ? bus.req_a : '1;
                        w_resp_div0_nxt  = 1'b1;
                        w_resp_valid_nxt = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else if (w_ovf_case) begin
                        w_resp_data_nxt  = bus.req_op[1] ? '0 : bus.req_a;
                        w_resp_ovf_nxt   = 1'b1;
                        w_resp_valid_nxt = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_state_nxt = S_CALC;
                        if (bus.req_op[2]) begin
                            w_acc_nxt   = {{XLEN{1'b0}}, w_mag_a};
                            w_mcand_nxt = {{XLEN{1'b0}}, w_mag_b};
                        end else begin
                            w_acc_nxt    = '0;
                            w_mcand_nxt  = {{XLEN{1'b0}}, w_mag_a};
                            w_mplier_nxt = w_mag_b;
                        end
                    end
                end
            end
            S_CALC: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_op[2]) begin
                    w_acc_nxt = w_div_ge ? {w_div_diff, r_acc[XLEN-2:0], 1'b1}
                                         : {r_acc[PW-2:0], 1'b0};
                end else begin
                    w_acc_nxt    = w_mul_acc;
                    w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
                    w_mplier_nxt = {1'b0, r_mplier[XLEN-1:1]};
                end
                if (r_cnt == CNT_W'(XLEN - 1)) begin
                    w_state_nxt = S_FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                // No multiplier bits left above the one just consumed
                else if (!r_op[2] && (r_mplier[XLEN-1:1] == '0)) begin
                    w_state_nxt = S_FIX;
                end
`endif
            end
            S_FIX: begin
                w_resp_data_nxt  = w_result;
                w_resp_valid_nxt = 1'b1;
                w_state_nxt      = S_DONE;
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Flush drops whatever is in flight, including an unclaimed result
        if (flush) begin
            w_state_nxt      = S_IDLE;
            w_resp_valid_nxt = 1'b0;
        end

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_div0  <= 1'b0;
            r_resp_ovf   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_op         <= w_op_nxt;
            r_neg_q      <= w_neg_q_nxt;
            r_neg_r      <= w_neg_r_nxt;
            r_acc        <= w_acc_nxt;
            r_mcand      <= w_mcand_nxt;
            r_mplier     <= w_mplier_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_div0  <= w_resp_div0_nxt;
            r_resp_ovf   <= w_resp_ovf_nxt;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_div0  = r_resp_div0;
    assign bus.resp_ovf   = r_resp_ovf;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vector table plus corner-case sequences
// (backpressure, flush, reset mid-op) for muldiv_iter at XLEN=32.
module tb_muldiv_iter;
    localparam int unsigned XLEN  = 32;
    localparam int          LIMIT = 200;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        div0;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_pass;

    muldiv_iter_if #(.XLEN(XLEN)) bus ();

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Expected cycles from accept edge to the edge that sees resp_valid
    function automatic int exp_latency(input vec_t v);
        int          n;
        logic [31:0] mag;
        if (v.div0 || v.ovf) return 1;
        n   = 0;
        mag = (!v.op[1] && v.b[31]) ? (~v.b + 32'd1) : v.b;
`ifdef MULDIV_EARLY_OUT_EN
        if (!v.op[2]) begin
            for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
            if (n < 1) n = 1;
            return n + 2;
        end
`endif
        if (mag == 32'h0) n = 0;
        return XLEN + 2;
    endfunction

    // Issue one op from a falling edge, wait for the response, then take it
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output logic div0, output logic ovf,
                          output int lat);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = ~a;
        bus.req_b     = 32'h0;
        lat = 1;
        while (!bus.resp_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        data = bus.resp_data;
        div0 = bus.resp_div0;
        ovf  = bus.resp_ovf;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    vec_t        vecs[16];
    logic [31:0] r_data;
    logic        r_div0;
    logic        r_ovf;
    int          lat;
    int          bad;

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0};
        vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 1'b0};
        vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 1'b0};
        vecs[8]  = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1'b1, 1'b0};
        vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
        vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1};
        vecs[12] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[13] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0};
        vecs[14] = '{OP_MUL,    32'h12345678, 32'h00000100, 32'h34567800, 1'b0, 1'b0};
        vecs[15] = '{OP_MUL,    32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25,       1'b0, 1'b0};

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready",  64'(bus.req_ready),  64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data",  64'(bus.resp_data),  64'd0);
        check("rst_flags",      64'({bus.resp_div0, bus.resp_ovf}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_data, r_div0, r_ovf, lat);
            check($sformatf("v%0d_data", i), 64'(r_data), 64'(vecs[i].data));
            check($sformatf("v%0d_flags", i), 64'({r_div0, r_ovf}), 64'({vecs[i].div0, vecs[i].ovf}));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i])));
            check($sformatf("v%0d_idle_after", i), 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        end

        // Backpressure: result held stable for 10 cycles, then released
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(XLEN + 2));
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd14 || bus.req_ready !== 1'b0) bad++;
        end
        check("bp_hold_bad_cycles", 64'(bad), 64'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("bp_release", 64'({bus.req_ready, bus.resp_valid}), 64'b10);

        // Flush at CALC cycle 5
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_a     = 32'hFFFFFFF9;
        bus.req_b     = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_busy_ready", 64'(bus.req_ready), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) bad++;
        end
        check("flush_no_resp", 64'(bad), 64'd0);

        // Flush beats a simultaneous request
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd0;
        flush         = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        check("flush_vs_req", 64'(bad), 64'd0);

        // Reset mid-op (flush also high: reset wins)
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        check("rstmid_ready_valid", 64'({bus.req_ready, bus.resp_valid}), 64'b10);
        check("rstmid_data", 64'(bus.resp_data), 64'd0);
        check("rstmid_flags", 64'({bus.resp_div0, bus.resp_ovf}), 64'd0);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, r_data, r_div0, r_ovf, lat);
        check("post_rst_data", 64'(r_data), 64'hFFFFFFFD);
        check("post_rst_latency", 64'(lat), 64'(XLEN + 2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
